vga_timing_gen: RTL and testbench

Parametrised horizontal/vertical raster timing generator. It is the next generation of the two-digit H/V position counter. It adds per-axis region phases (active, front porch, sync, back porch), sync generation with selectable polarity, data-enable, line/frame start strobes and a pixel-clock enable. It sits between the clock domain root and the pixel pipeline / VGA output pads.

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/vga_axis_timer.sv | 68 ++++++
 rtl/vga_timing_gen.sv | 90 +++++++++
 tb/tb_vga_timing_gen.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared definitions for the raster timing generator: phase encoding and
// the parameter sets for the supported video modes.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } phase_t;

  // 640x480@60, 25.175 MHz pixel clock, negative syncs
  localparam int M640_H_ACTIVE = 640;
  localparam int M640_H_FP     = 16;
  localparam int M640_H_SYNC   = 96;
  localparam int M640_H_BP     = 48;
  localparam int M640_V_ACTIVE = 480;
  localparam int M640_V_FP     = 10;
  localparam int M640_V_SYNC   = 2;
  localparam int M640_V_BP     = 33;
  localparam bit M640_HS_POL   = 1'b0;
  localparam bit M640_VS_POL   = 1'b0;

  // 800x600@60, 40 MHz pixel clock, positive syncs
  localparam int M800_H_ACTIVE = 800;
  localparam int M800_H_FP     = 40;
  localparam int M800_H_SYNC   = 128;
  localparam int M800_H_BP     = 88;
  localparam int M800_V_ACTIVE = 600;
  localparam int M800_V_FP     = 1;
  localparam int M800_V_SYNC   = 4;
  localparam int M800_V_BP     = 23;
  localparam bit M800_HS_POL   = 1'b1;
  localparam bit M800_VS_POL   = 1'b1;

endpackage

// File: rtl/vga_axis_timer.sv
// One raster axis: position counter plus region phase, both updated on the
// same edge so count and phase never disagree.
//
//   state     | meaning
//   ----------+-----------------------------------------
//   PH_ACTIVE | count in [0, A-1], visible region
//   PH_FP     | count in [A, A+FP-1], front porch
//   PH_SYNC   | count in [A+FP, A+FP+SYNC-1], sync pulse
//   PH_BP     | remaining counts up to the terminal count
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int W    = 12,
  parameter int A    = 640,
  parameter int FP   = 16,
  parameter int SYNC = 96,
  parameter int BP   = 48
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_adv,
  output logic [W-1:0] count,
  output logic [1:0]   phase,
  output logic         wrap
);

  localparam int TOTAL = A + FP + SYNC + BP;
  localparam logic [W-1:0] TERM       = W'(TOTAL - 1);
  localparam logic [W-1:0] FP_START   = W'(A);
  localparam logic [W-1:0] SYNC_START = W'(A + FP);
  localparam logic [W-1:0] BP_START   = W'(A + FP + SYNC);
  localparam logic [W-1:0] ONE        = W'(1);

  phase_t       state_q, state_d;
  logic [W-1:0] count_q, count_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      count_q <= TERM;
      state_q <= PH_BP;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // Phase transitions look at the new count so both land on the same edge.
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    if (i_adv) begin
      count_d = (count_q == TERM) ? '0 : count_q + ONE;
      unique case (state_q)
        PH_ACTIVE: if (count_d == FP_START)   state_d = PH_FP;
        PH_FP:     if (count_d == SYNC_START) state_d = PH_SYNC;
        PH_SYNC:   if (count_d == BP_START)   state_d = PH_BP;
        PH_BP:     if (count_d == '0)         state_d = PH_ACTIVE;
      endcase
    end
  end

  always_comb begin
    count = count_q;
    phase = state_q;
    wrap  = (count_q == TERM);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: two axis timers combined into sync levels,
// data-enable and registered line/frame start strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int W        = 12,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_hcnt,
  output logic [W-1:0] o_vcnt,
  output logic         o_hsync,
  output logic         o_vsync,
  output logic         o_de,
  output logic         o_sol,
  output logic         o_sof
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2 ** W || V_TOTAL > 2 ** W) begin : g_total_chk
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter width W");
  end
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_region_chk
    $error("vga_timing_gen: every timing region must be at least 1");
  end

  logic [1:0] hphase, vphase;
  logic       h_wrap, v_wrap;
  logic       v_adv;
  logic       sol_q, sof_q;

  assign v_adv = i_en & h_wrap;

  vga_axis_timer #(
    .W(W), .A(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_adv (i_en),
    .count (o_hcnt),
    .phase (hphase),
    .wrap  (h_wrap)
  );

  vga_axis_timer #(
    .W(W), .A(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_adv (v_adv),
    .count (o_vcnt),
    .phase (vphase),
    .wrap  (v_wrap)
  );

  // Strobes fire on the edge where the counters wrap to zero; a held
  // (disabled) cycle never re-fires them.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      sol_q <= 1'b0;
      sof_q <= 1'b0;
    end else begin
      sol_q <= i_en & h_wrap;
      sof_q <= i_en & h_wrap & v_wrap;
    end
  end

  always_comb begin
    o_hsync = (hphase == PH_SYNC) ? HS_POL : ~HS_POL;
    o_vsync = (vphase == PH_SYNC) ? VS_POL : ~VS_POL;
    o_de    = (hphase == PH_ACTIVE) && (vphase == PH_ACTIVE);
    o_sol   = sol_q;
    o_sof   = sof_q;
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 mode and a tiny 4-bit mode,
// each checked against an arithmetic raster model every cycle.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hfp, hs, hbp;
    int va, vfp, vs, vbp;
    bit hpol, vpol;
  } mode_t;

  typedef struct {
    int h, v;
    bit sol, sof;
  } mstate_t;

  typedef struct {
    bit rst, en;
    int h, v;
    bit de, hs, vs, sol, sof;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b0, en_a = 1'b0;
  logic [11:0] hcnt_a, vcnt_a;
  logic        hs_a, vs_a, de_a, sol_a, sof_a;

  logic        rst_b = 1'b0, en_b = 1'b0;
  logic [3:0]  hcnt_b, vcnt_b;
  logic        hs_b, vs_b, de_b, sol_b, sof_b;

  int tests = 0;
  int failed = 0;

  mode_t   mode_a, mode_b;
  mstate_t ms_a, ms_b;

  vga_timing_gen dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_en(en_a),
    .o_hcnt(hcnt_a), .o_vcnt(vcnt_a), .o_hsync(hs_a), .o_vsync(vs_a),
    .o_de(de_a), .o_sol(sol_a), .o_sof(sof_a)
  );

  vga_timing_gen #(
    .W(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_en(en_b),
    .o_hcnt(hcnt_b), .o_vcnt(vcnt_b), .o_hsync(hs_b), .o_vsync(vs_b),
    .o_de(de_b), .o_sol(sol_b), .o_sof(sof_b)
  );

  function automatic mstate_t model_step(mode_t m, mstate_t s, bit rst, bit en);
    mstate_t n = s;
    int ht = m.ha + m.hfp + m.hs + m.hbp;
    int vt = m.va + m.vfp + m.vs + m.vbp;
    n.sol = 1'b0;
    n.sof = 1'b0;
    if (!rst) begin
      n.h = ht - 1;
      n.v = vt - 1;
    end else if (en) begin
      n.h = (s.h + 1) % ht;
      if (n.h == 0) begin
        n.v   = (s.v + 1) % vt;
        n.sol = 1'b1;
        n.sof = (n.v == 0);
      end
    end
    return n;
  endfunction

  task automatic check(string name, mode_t m, mstate_t s, int h, int v,
                       bit de, bit hs, bit vs, bit sol, bit sof);
    bit in_hs = (s.h >= m.ha + m.hfp) && (s.h < m.ha + m.hfp + m.hs);
    bit in_vs = (s.v >= m.va + m.vfp) && (s.v < m.va + m.vfp + m.vs);
    bit e_hs  = in_hs ? m.hpol : ~m.hpol;
    bit e_vs  = in_vs ? m.vpol : ~m.vpol;
    bit e_de  = (s.h < m.ha) && (s.v < m.va);
    tests++;
    if (h != s.h || v != s.v || de != e_de || hs != e_hs || vs != e_vs ||
        sol != s.sol || sof != s.sof) begin
      failed++;
      $display("FAIL %s @%0t: got h=%0d v=%0d de=%0b hs=%0b vs=%0b sol=%0b sof=%0b, want h=%0d v=%0d de=%0b hs=%0b vs=%0b sol=%0b sof=%0b",
               name, $time, h, v, de, hs, vs, sol, sof,
               s.h, s.v, e_de, e_hs, e_vs, s.sol, s.sof);
    end
  endtask

  task automatic cyc_a(bit rst, bit en);
    rst_a = rst;
    en_a  = en;
    @(posedge clk);
    #1;
    ms_a = model_step(mode_a, ms_a, rst, en);
    check("model_a", mode_a, ms_a, int'(hcnt_a), int'(vcnt_a), de_a, hs_a, vs_a, sol_a, sof_a);
  endtask

  task automatic cyc_b(bit rst, bit en);
    rst_b = rst;
    en_b  = en;
    @(posedge clk);
    #1;
    ms_b = model_step(mode_b, ms_b, rst, en);
    check("model_b", mode_b, ms_b, int'(hcnt_b), int'(vcnt_b), de_b, hs_b, vs_b, sol_b, sof_b);
  endtask

  task automatic expect_int(string name, int got, int want);
    tests++;
    if (got != want) begin
      failed++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Clocks between the next two sof pulses on dut_b; en alternates if alt.
  task automatic sof_period_b(string name, bit alt, int want);
    int first = -1;
    int second = -1;
    for (int c = 0; c < 400 && second < 0; c++) begin
      cyc_b(1'b1, alt ? (c % 2 == 0) : 1'b1);
      if (sof_b) begin
        if (first < 0) first = c;
        else second = c;
      end
    end
    expect_int(name, (second < 0) ? -1 : second - first, want);
  endtask

  vec_t vecs[10];

  initial begin
    int hs_low, hs_first, hs_last, de_fall, sol_first, sol_second;
    int de_cnt, vs_cnt, vs_first_h, vs_first_v, guard;

    mode_a = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    mode_b = '{4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b1};
    ms_a = '{799, 524, 1'b0, 1'b0};
    ms_b = '{6, 4, 1'b0, 1'b0};

    //           rst en  h    v    de hs vs sol sof
    vecs[0] = '{0, 1, 799, 524, 0, 1, 1, 0, 0};
    vecs[1] = '{0, 1, 799, 524, 0, 1, 1, 0, 0};
    vecs[2] = '{0, 1, 799, 524, 0, 1, 1, 0, 0};
    vecs[3] = '{1, 1, 0,   0,   1, 1, 1, 1, 1};
    vecs[4] = '{1, 1, 1,   0,   1, 1, 1, 0, 0};
    vecs[5] = '{1, 0, 1,   0,   1, 1, 1, 0, 0};
    vecs[6] = '{1, 1, 2,   0,   1, 1, 1, 0, 0};
    vecs[7] = '{0, 0, 799, 524, 0, 1, 1, 0, 0};
    vecs[8] = '{1, 0, 799, 524, 0, 1, 1, 0, 0};
    vecs[9] = '{1, 1, 0,   0,   1, 1, 1, 1, 1};

    for (int i = 0; i < 10; i++) begin
      rst_a = vecs[i].rst;
      en_a  = vecs[i].en;
      @(posedge clk);
      #1;
      ms_a = model_step(mode_a, ms_a, vecs[i].rst, vecs[i].en);
      tests++;
      if (int'(hcnt_a) != vecs[i].h || int'(vcnt_a) != vecs[i].v || de_a != vecs[i].de ||
          hs_a != vecs[i].hs || vs_a != vecs[i].vs || sol_a != vecs[i].sol || sof_a != vecs[i].sof) begin
        failed++;
        $display("FAIL vec%0d: got h=%0d v=%0d de=%0b hs=%0b vs=%0b sol=%0b sof=%0b, want h=%0d v=%0d de=%0b hs=%0b vs=%0b sol=%0b sof=%0b",
                 i, hcnt_a, vcnt_a, de_a, hs_a, vs_a, sol_a, sof_a,
                 vecs[i].h, vecs[i].v, vecs[i].de, vecs[i].hs, vecs[i].vs, vecs[i].sol, vecs[i].sof);
      end
    end

    // Line 0 of the default mode, fully enabled.
    cyc_a(1'b0, 1'b1);
    hs_low = 0; hs_first = -1; hs_last = -1; de_fall = -1;
    for (int i = 0; i < 800; i++) begin
      cyc_a(1'b1, 1'b1);
      if (!hs_a) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(hcnt_a);
        hs_last = int'(hcnt_a);
      end
      if (!de_a && de_fall < 0) de_fall = int'(hcnt_a);
    end
    expect_int("hsync_low_len", hs_low, 96);
    expect_int("hsync_first", hs_first, 656);
    expect_int("hsync_last", hs_last, 751);
    expect_int("de_fall_h", de_fall, 640);
    cyc_a(1'b1, 1'b1);
    expect_int("wrap_h", int'(hcnt_a), 0);
    expect_int("wrap_v", int'(vcnt_a), 1);
    expect_int("wrap_sol", int'(sol_a), 1);
    expect_int("wrap_sof", int'(sof_a), 0);

    // Randomised enable with rare resets.
    for (int i = 0; i < 1700; i++)
      cyc_a($urandom_range(0, 499) != 0, $urandom_range(0, 3) != 0);

    // Alternating enable: sol period doubles to 1600 clocks.
    sol_first = -1; sol_second = -1;
    for (int c = 0; c < 4000 && sol_second < 0; c++) begin
      cyc_a(1'b1, (c % 2) == 0);
      if (sol_a) begin
        if (sol_first < 0) sol_first = c;
        else sol_second = c;
      end
    end
    expect_int("sol_period_alt", (sol_second < 0) ? -1 : sol_second - sol_first, 1600);

    // Reset mid-line at hcnt 300.
    guard = 0;
    while (int'(hcnt_a) != 300 && guard < 2000) begin
      cyc_a(1'b1, 1'b1);
      guard++;
    end
    expect_int("reach_h300", int'(hcnt_a), 300);
    cyc_a(1'b0, 1'b1);
    expect_int("midreset_h", int'(hcnt_a), 799);
    expect_int("midreset_v", int'(vcnt_a), 524);

    // Small mode: one full frame with structural counts.
    cyc_b(1'b0, 1'b1);
    de_cnt = 0; vs_cnt = 0; vs_first_h = -1; vs_first_v = -1;
    for (int i = 0; i < 35; i++) begin
      cyc_b(1'b1, 1'b1);
      if (de_b) de_cnt++;
      if (vs_b) begin
        vs_cnt++;
        if (vs_first_h < 0) begin
          vs_first_h = int'(hcnt_b);
          vs_first_v = int'(vcnt_b);
        end
      end
    end
    expect_int("b_de_per_frame", de_cnt, 8);
    expect_int("b_vsync_len", vs_cnt, 7);
    expect_int("b_vsync_start_h", vs_first_h, 0);
    expect_int("b_vsync_start_v", vs_first_v, 3);

    sof_period_b("b_sof_period", 1'b0, 35);
    sof_period_b("b_sof_period_alt", 1'b1, 70);

    for (int i = 0; i < 600; i++)
      cyc_b($urandom_range(0, 149) != 0, $urandom_range(0, 2) != 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
